// File: rtl/hilo_ctrl.sv
// HI/LO register controller for a multi-cycle multiplier: sequences the
// multiplier enable, captures the product into HI/LO and services MTHI/MTLO.
module hilo_ctrl #(
  parameter int MULT_CYCLES = 33,
  parameter int W           = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         mthi,
  input  logic         mtlo,
  input  logic [W-1:0] wr_data,
  input  logic [W-1:0] mult_hi,
  input  logic [W-1:0] mult_lo,
  output logic         mult_control,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int CW = $clog2(MULT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(MULT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, CAPTURE} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           mctl_q, mctl_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;

  // A start in IDLE wins over simultaneous MTHI/MTLO, which are then dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mctl_d  = mctl_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          mctl_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          if (mthi) hi_d = wr_data;
          if (mtlo) lo_d = wr_data;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = CAPTURE;
          mctl_d  = 1'b0;
        end
      end
      CAPTURE: begin
        hi_d    = mult_hi;
        lo_d    = mult_lo;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        mctl_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mctl_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mctl_q  <= mctl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign mult_control = mctl_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign hi           = hi_q;
  assign lo           = lo_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Bench for hilo_ctrl: table-driven MTHI/MTLO vectors, scoreboarded products,
// and hand-written multiply, overlap and reset-abort sequences.
module tb_hilo_ctrl;

  localparam logic [31:0] GARB = 32'hDEADBEEF;

  logic        clk;
  logic        reset;
  logic        start, mthi, mtlo;
  logic [31:0] wr_data, mult_hi, mult_lo;
  logic        mult_control, busy, done;
  logic [31:0] hi, lo;

  int compared   = 0;
  int mismatched = 0;
  int doneCount  = 0;
  int mcRun      = 0;
  logic [31:0] modelHi, modelLo;
  logic [63:0] expQ[$];

  typedef struct {
    logic        mthi;
    logic        mtlo;
    logic [31:0] wd;
    logic [31:0] expHi;
    logic [31:0] expLo;
    logic        expDone;
  } vec_t;
  vec_t vecs[5];

  hilo_ctrl #(.MULT_CYCLES(33), .W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .mthi(mthi), .mtlo(mtlo),
    .wr_data(wr_data), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .mult_control(mult_control), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every done pulse must match the oldest pending product,
  // and every mult_control pulse not cut short by reset must last 33 cycles.
  always @(negedge clk) begin
    logic [63:0] e;
    if (done) begin
      doneCount++;
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpectedDone: got done=1 with hi=0x%08h lo=0x%08h expected no pulse", hi, lo);
      end else begin
        e = expQ.pop_front();
        checkOutput("captureHi", hi, e[63:32]);
        checkOutput("captureLo", lo, e[31:0]);
      end
    end
    if (!reset) mcRun = 0;
    else if (mult_control) mcRun++;
    else if (mcRun > 0) begin
      checkOutput("mctlPulseLen", mcRun, 33);
      mcRun = 0;
    end
  end

  task automatic applyStimulus(input logic [31:0] mh, input logic [31:0] ml,
                               input bit extraStart, input bit runWrites, input bit writeWithStart);
    logic [31:0] holdHi, holdLo;
    holdHi  = modelHi;
    holdLo  = modelLo;
    mult_hi = GARB;
    mult_lo = GARB;
    start   = 1'b1;
    if (writeWithStart) begin
      mthi    = 1'b1;
      mtlo    = 1'b1;
      wr_data = 32'h55555555;
    end
    expQ.push_back({mh, ml});
    step();
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    checkOutput("busyE0", busy, 1);
    checkOutput("mctlE0", mult_control, 1);
    checkOutput("hiHeldE0", hi, holdHi);
    checkOutput("loHeldE0", lo, holdLo);
    for (int k = 1; k <= 32; k++) begin
      if (extraStart && k == 10) start = 1'b1;
      if (runWrites && k == 5) begin mthi = 1'b1; wr_data = 32'h12345678; end
      if (runWrites && k == 6) begin mtlo = 1'b1; wr_data = 32'h9ABCDEF0; end
      step();
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    end
    checkOutput("mctlE32", mult_control, 1);
    checkOutput("hiHeldRun", hi, holdHi);
    checkOutput("loHeldRun", lo, holdLo);
    step();
    checkOutput("mctlE33", mult_control, 0);
    checkOutput("doneE33", done, 0);
    checkOutput("busyE33", busy, 1);
    mult_hi = mh;
    mult_lo = ml;
    step();
    checkOutput("doneE34", done, 1);
    step();
    checkOutput("doneE35", done, 0);
    checkOutput("busyE35", busy, 0);
    checkOutput("hiE35", hi, mh);
    checkOutput("loE35", lo, ml);
    modelHi = mh;
    modelLo = ml;
    mult_hi = GARB;
    mult_lo = GARB;
    repeat (3) step();
    checkOutput("busyIdle", busy, 0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h12345678, 32'h12345678, 32'h0000002A, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h12345678, 32'h9ABCDEF0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0F0F0F0F, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0F0F0F0F, 1'b0};

    reset = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    wr_data = '0; mult_hi = GARB; mult_lo = GARB;
    modelHi = '0; modelLo = '0;
    #3;
    checkOutput("rstMctl", mult_control, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstHi", hi, 0);
    checkOutput("rstLo", lo, 0);
    @(negedge clk);
    reset = 1'b1;
    step();

    $display("[TB] basic multiply 0 x 42");
    applyStimulus(32'h00000000, 32'h0000002A, 1'b0, 1'b0, 1'b0);

    $display("[TB] IDLE MTHI/MTLO vectors");
    for (int i = 0; i < 5; i++) begin
      mthi = vecs[i].mthi;
      mtlo = vecs[i].mtlo;
      wr_data = vecs[i].wd;
      step();
      mthi = 1'b0; mtlo = 1'b0;
      checkOutput($sformatf("vec%0dHi", i), hi, vecs[i].expHi);
      checkOutput($sformatf("vec%0dLo", i), lo, vecs[i].expLo);
      checkOutput($sformatf("vec%0dDone", i), done, vecs[i].expDone);
      modelHi = vecs[i].expHi;
      modelLo = vecs[i].expLo;
    end

    $display("[TB] -3*5 with ignored start and writes while busy");
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFF1, 1'b1, 1'b1, 1'b0);

    $display("[TB] start together with MTHI/MTLO");
    applyStimulus(32'h00000007, 32'h00000001, 1'b0, 1'b0, 1'b1);

    $display("[TB] reset during RUN");
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (15) step();
    checkOutput("preRstMctl", mult_control, 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("abortMctl", mult_control, 0);
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortDone", done, 0);
    checkOutput("abortHi", hi, 0);
    checkOutput("abortLo", lo, 0);
    modelHi = '0;
    modelLo = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) step();
    checkOutput("postAbortBusy", busy, 0);
    checkOutput("postAbortHi", hi, 0);
    applyStimulus(32'h00000123, 32'h89ABCDEF, 1'b0, 1'b0, 1'b0);

    checkOutput("queueEmpty", expQ.size(), 0);
    checkOutput("doneCount", doneCount, 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 33, which is the number of cycles mult_control is held high per multiply.
REQ-002 The block SHALL have parameter W, default 32, which is the data width of HI, LO and the multiplier results.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low; 0 clears all state immediately.
REQ-005 start  input  1  one-cycle request from CPU control to begin a MULT.
REQ-006 mthi  input  1  write wr_data into HI (MTHI).
REQ-007 mtlo  input  1  write wr_data into LO (MTLO).
REQ-008 wr_data  input  W  operand for mthi/mtlo.
REQ-009 mult_hi  input  W  multiplier upper result (its out0).
REQ-010 mult_lo  input  W  multiplier lower result (its out1).
REQ-011 mult_control  output  1  registered enable to the multiplier's control input.
REQ-012 busy  output  1  high while a multiply is in flight; CPU stalls on it.
REQ-013 done  output  1  one-cycle pulse when HI/LO have been updated with a product.
REQ-014 hi  output  W  HI register (MFHI source).
REQ-015 lo  output  W  LO register (MFLO source).

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and CAPTURE, with IDLE as the reset state.
REQ-017 In IDLE, a sampled start SHALL cause the FSM to go to RUN, set mult_control=1 and clear the cycle counter to 0.
REQ-018 In RUN, the counter SHALL increment once per cycle.
REQ-019 In RUN, when counter==MULT_CYCLES-1, the FSM SHALL go to CAPTURE and set mult_control=0.
REQ-020 mult_control SHALL be high for exactly MULT_CYCLES consecutive cycles per accepted start, never more; the multiplier keeps counting if held high.
REQ-021 In CAPTURE, the block SHALL set hi<=mult_hi, lo<=mult_lo and done<=1, then return to IDLE.
REQ-022 done SHALL be high for exactly one cycle per product.
REQ-023 Latency: start sampled at edge E0 -> hi/lo/done updated at edge E0+MULT_CYCLES+1, which is E34 at the default.
REQ-024 busy SHALL equal (state != IDLE) and be registered; busy is high from E0 to E0+MULT_CYCLES+1.
REQ-025 A start arriving while busy SHALL be ignored and SHALL NOT be queued.
REQ-026 In IDLE, mthi SHALL write wr_data to hi and mtlo SHALL write wr_data to lo on the next edge, with no done pulse.
REQ-027 mthi and mtlo asserted together SHALL write both registers.
REQ-028 mthi/mtlo while busy SHALL be ignored.
REQ-029 If start and mthi/mtlo are asserted in the same IDLE cycle, start SHALL win and the writes SHALL be dropped.
REQ-030 The counter SHALL be ceil(log2(MULT_CYCLES+1)) bits wide and SHALL NOT wrap within a RUN.
REQ-031 hi/lo SHALL hold their value in all cases not listed above.

Reset
REQ-032 reset=0 SHALL asynchronously force state=IDLE, counter=0, mult_control=0, busy=0, done=0, hi=0 and lo=0.
REQ-033 Reset mid-RUN SHALL abort the multiply with no capture and no done pulse; mult_control=0 then clears the multiplier on its next clock.
REQ-034 After reset is released, the first accepted start SHALL behave exactly as from power-up.

Verification
REQ-035 The bench SHALL cover: reset, then start pulse with model driving mult_hi=0x00000000, mult_lo=0x0000002A valid from E33 -> mult_control high exactly 33 cycles, done at E34, hi=0, lo=42.
REQ-036 The bench SHALL cover: start with mult_hi=0xFFFFFFFF, mult_lo=0xFFFFFFF1 (-3*5) -> hi=0xFFFFFFFF, lo=0xFFFFFFF1, single done pulse, busy low at E35.
REQ-037 The bench SHALL cover: second start at E10 while busy -> ignored, still one done, mult_control pulse still 33 cycles.
REQ-038 The bench SHALL cover: IDLE mthi with wr_data=0x12345678, next cycle mtlo with wr_data=0x9ABCDEF0 -> hi=0x12345678, lo=0x9ABCDEF0, done stays 0; the same writes during RUN -> no change.
REQ-039 The bench SHALL cover: start+mthi in the same cycle -> multiply runs and hi is taken from mult_hi, not wr_data.
REQ-040 The bench SHALL cover: reset asserted at E15 of RUN -> all outputs 0 immediately, no done; a new start after release completes normally.
